// File: rtl/fft_xbar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_xbar_pkg
// Description : Shared mode encodings, bit-reversal and lane-offset helpers
//               for the FFT stage crossbar.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_xbar_pkg;

    localparam logic [1:0] MODE_PASS    = 2'b00;
    localparam logic [1:0] MODE_GATHER  = 2'b01;
    localparam logic [1:0] MODE_SCATTER = 2'b10;
    localparam logic [1:0] MODE_BITREV  = 2'b11;

    function automatic int bitrev(input int idx, input int log2n);
        int r;
        r = 0;
        for (int k = 0; k < log2n; k++) begin
            r = (r << 1) | ((idx >> k) & 1);
        end
        return r;
    endfunction

    // Real lanes occupy the upper half of the packed vector, imaginary the lower.
    function automatic int lane_re_lsb(input int lane, input int bw, input int n);
        return bw * (n + lane);
    endfunction

    function automatic int lane_im_lsb(input int lane, input int bw);
        return bw * lane;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_xbar_perm.sv
`default_nettype none
// ============================================================================
// Module      : fft_xbar_perm
// Description : Combinational lane permutation (pass/gather/scatter/bitrev)
//               applied identically to real and imaginary lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_xbar_perm
    import fft_xbar_pkg::*;
#(
    parameter  int BIT_WIDTH = 32,
    parameter  int SIZE_FFT  = 8,
    localparam int c_LOG2N   = $clog2(SIZE_FFT),
    localparam int STAGE_W   = (c_LOG2N > 1) ? $clog2(c_LOG2N) : 1,
    localparam int c_VEC_W   = 2 * SIZE_FFT * BIT_WIDTH
) (
    input  logic [c_VEC_W-1:0] i_vec,
    input  logic [1:0]         i_mode,
    input  logic [STAGE_W-1:0] i_stage,
    output logic [c_VEC_W-1:0] o_vec,
    output logic               o_illegal
);

    logic [c_LOG2N-1:0] w_src [SIZE_FFT];

    // w_src[k] is the input lane that feeds output lane k.
    always_comb begin
        int s;
        int m;
        int i0;
        int i1;
        s  = int'(i_stage);
        m  = 1;
        i0 = 0;
        i1 = 0;
        o_illegal = ((i_mode == MODE_GATHER) || (i_mode == MODE_SCATTER)) &&
                    (s >= c_LOG2N);
        for (int k = 0; k < SIZE_FFT; k++) begin
            w_src[k] = c_LOG2N'(k);
        end
        if (!o_illegal) begin
            m = 1 << s;
            case (i_mode)
                MODE_GATHER: begin
                    for (int b = 0; b < SIZE_FFT / 2; b++) begin
                        i0 = ((b >> s) << (s + 1)) | (b & (m - 1));
                        i1 = i0 + m;
                        w_src[2 * b]     = c_LOG2N'(i0);
                        w_src[2 * b + 1] = c_LOG2N'(i1);
                    end
                end
                MODE_SCATTER: begin
                    for (int b = 0; b < SIZE_FFT / 2; b++) begin
                        i0 = ((b >> s) << (s + 1)) | (b & (m - 1));
                        i1 = i0 + m;
                        w_src[i0] = c_LOG2N'(2 * b);
                        w_src[i1] = c_LOG2N'(2 * b + 1);
                    end
                end
                MODE_BITREV: begin
                    for (int k = 0; k < SIZE_FFT; k++) begin
                        w_src[k] = c_LOG2N'(bitrev(k, c_LOG2N));
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_vec = '0;
        for (int k = 0; k < SIZE_FFT; k++) begin
            o_vec[lane_re_lsb(k, BIT_WIDTH, SIZE_FFT) +: BIT_WIDTH] =
                i_vec[lane_re_lsb(int'(w_src[k]), BIT_WIDTH, SIZE_FFT) +: BIT_WIDTH];
            o_vec[lane_im_lsb(k, BIT_WIDTH) +: BIT_WIDTH] =
                i_vec[lane_im_lsb(int'(w_src[k]), BIT_WIDTH) +: BIT_WIDTH];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_stage_crossbar_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fft_stage_crossbar_pipe
// Description : Runtime-configurable FFT crossbar followed by a 2-entry
//               elastic buffer with val/rdy on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_stage_crossbar_pipe
    import fft_xbar_pkg::*;
#(
    parameter  int BIT_WIDTH = 32,
    parameter  int SIZE_FFT  = 8,
    localparam int c_LOG2N   = $clog2(SIZE_FFT),
    localparam int STAGE_W   = (c_LOG2N > 1) ? $clog2(c_LOG2N) : 1,
    localparam int c_VEC_W   = 2 * SIZE_FFT * BIT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [c_VEC_W-1:0] recv_msg,
    input  logic [1:0]         recv_cfg_mode,
    input  logic [STAGE_W-1:0] recv_cfg_stage,
    input  logic               recv_val,
    output logic               recv_rdy,
    output logic [c_VEC_W-1:0] send_msg,
    output logic               send_val,
    input  logic               send_rdy,
    output logic               cfg_err,
    output logic [1:0]         occupancy
);

    logic [c_VEC_W-1:0] w_perm;
    logic               w_illegal;
    logic               w_enq;
    logic               w_deq;

    logic [c_VEC_W-1:0] r_mem [2];
    logic               r_head;
    logic               r_tail;
    logic [1:0]         r_occ;
    logic               r_cfg_err;

    fft_xbar_perm #(
        .BIT_WIDTH (BIT_WIDTH),
        .SIZE_FFT  (SIZE_FFT)
    ) u_perm (
        .i_vec     (recv_msg),
        .i_mode    (recv_cfg_mode),
        .i_stage   (recv_cfg_stage),
        .o_vec     (w_perm),
        .o_illegal (w_illegal)
    );

    // Ready/valid come only from registered occupancy: no comb path through.
    assign recv_rdy  = (r_occ != 2'd2);
    assign send_val  = (r_occ != 2'd0);
    assign send_msg  = r_mem[r_head];
    assign occupancy = r_occ;
    assign cfg_err   = r_cfg_err;

    assign w_enq = recv_val && recv_rdy;
    assign w_deq = send_val && send_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem[0]  <= '0;
            r_mem[1]  <= '0;
            r_head    <= 1'b0;
            r_tail    <= 1'b0;
            r_occ     <= 2'd0;
            r_cfg_err <= 1'b0;
        end else begin
            if (w_enq) begin
                r_mem[r_tail] <= w_perm;
                r_tail        <= ~r_tail;
            end
            if (w_deq) begin
                r_head <= ~r_head;
            end
            case ({w_enq, w_deq})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: ;
            endcase
            if (w_enq && w_illegal) begin
                r_cfg_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
